// File: rtl/latch_seq_pkg.sv
// Shared types and helpers for the latch strobe sequencer.
//   seq_state_e : sequencer phase encoding
//   cnt_width() : width of the phase down-counter for a given setup/pulse/hold
//                 timing, i.e. $clog2(max(TSETUP,TPULSE,THOLD)+1)
//   req_t       : request record at the default bus widths (addr, data)
package latch_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } seq_state_e;

  localparam int DW_DEF   = 8;
  localparam int AW_DEF   = 4;
  localparam int NREG_DEF = 16;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } req_t;

  function automatic int cnt_width(input int ts, input int tp, input int th);
    int m;
    m = ts;
    if (tp > m) m = tp;
    if (th > m) m = th;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/req_fifo2.sv
// Two-entry request FIFO with asynchronous active-high reset.
//   push_i/wdata_i : write an entry (taken when not full, or when full and
//                    popping in the same cycle)
//   pop_i          : discard the head entry (ignored when empty)
//   rdata_o        : current head entry (valid when !empty_o)
//   full_o/empty_o : occupancy flags
module req_fifo2 #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wptr_q;
  logic         rptr_q;
  logic [1:0]   cnt_q;
  logic [1:0]   cnt_d;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  // When full, a same-cycle pop frees the head slot, which is also the slot
  // the write pointer points at, so the new entry lands behind the survivor.
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= ~wptr_q;
      end
      if (do_pop) begin
        rptr_q <= ~rptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/latch_strobe_sequencer.sv
// Upstream driver for transparent-latch register macros. Buffers up to two
// write requests and, for each, drives the shared data bus and pulses one
// latch enable with setup / pulse / hold spacing so every latch closes on
// stable data.
//   clk, reset        : clock, asynchronous active-high reset
//   req_valid/ready   : request handshake (ready = FIFO not full)
//   req_addr/req_data : target latch index and value
//   lat_d             : latch data bus, changes only when a request is popped
//   lat_en            : registered one-hot latch enables (high = transparent)
//   busy              : sequence in progress or request pending
//   addr_err          : one-cycle pulse when a popped request's addr >= NREG
//
// state  | meaning
// IDLE   | nothing in flight; lat_d keeps last value
// SETUP  | lat_d driven, enables low, TSETUP cycles
// STROBE | selected enable high, TPULSE cycles
// HOLD   | enables low, lat_d held, THOLD cycles (skipped when THOLD = 0)
module latch_strobe_sequencer
  import latch_seq_pkg::*;
#(
  parameter int DW     = 8,
  parameter int NREG   = 16,
  parameter int AW     = 4,
  parameter int TSETUP = 1,
  parameter int TPULSE = 2,
  parameter int THOLD  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_data,
  output logic [DW-1:0]   lat_d,
  output logic [NREG-1:0] lat_en,
  output logic            busy,
  output logic            addr_err
);

  localparam int CW = cnt_width(TSETUP, TPULSE, THOLD);
  localparam logic [CW-1:0] LD_SETUP = CW'(TSETUP - 1);
  localparam logic [CW-1:0] LD_PULSE = CW'(TPULSE - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'((THOLD > 0) ? THOLD - 1 : 0);
  localparam logic [AW:0]   NREG_W   = (AW + 1)'(NREG);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } seq_req_t;

  localparam int RW = $bits(seq_req_t);

  seq_req_t        push_req;
  seq_req_t        head_req;
  logic [RW-1:0]   fifo_rdata;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push_w;
  logic            pop_w;
  logic            seq_done;
  logic            head_bad;

  seq_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic [NREG-1:0] sel_q;
  logic [NREG-1:0] lat_en_q;
  logic [DW-1:0]   lat_d_q;
  logic            addr_err_q;
  logic            ready_q;

  function automatic logic [NREG-1:0] decode(input logic [AW-1:0] a);
    logic [NREG-1:0] oh;
    oh = '0;
    for (int i = 0; i < NREG; i++) begin
      if (a == AW'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  assign push_req.addr = req_addr;
  assign push_req.data = req_data;
  assign head_req      = fifo_rdata;
  assign head_bad      = ({1'b0, head_req.addr} >= NREG_W);

  // ready_q keeps req_ready low until the first edge after reset releases.
  assign req_ready = ready_q && !fifo_full;
  assign push_w    = req_valid && req_ready;

  // Last edge of the current sequence: the next request can be popped
  // straight into SETUP without passing through IDLE.
  always_comb begin
    seq_done = 1'b0;
    case (state_q)
      ST_STROBE: seq_done = (cnt_q == '0) && (THOLD == 0);
      ST_HOLD:   seq_done = (cnt_q == '0);
      default:   seq_done = 1'b0;
    endcase
  end

  assign pop_w = !fifo_empty && ((state_q == ST_IDLE) || seq_done);

  req_fifo2 #(
    .W(RW)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push_w),
    .pop_i  (pop_w),
    .wdata_i(push_req),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      lat_en_q   <= '0;
      lat_d_q    <= '0;
      addr_err_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      ready_q    <= 1'b1;
      addr_err_q <= 1'b0;
      if (pop_w) begin
        // An out-of-range request still runs full timing; its select is all
        // zero, so STROBE drives no enable.
        state_q    <= ST_SETUP;
        cnt_q      <= LD_SETUP;
        lat_d_q    <= head_req.data;
        sel_q      <= decode(head_req.addr);
        addr_err_q <= head_bad;
        lat_en_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_IDLE;
          end
          ST_SETUP: begin
            if (cnt_q == '0) begin
              state_q  <= ST_STROBE;
              cnt_q    <= LD_PULSE;
              lat_en_q <= sel_q;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          ST_STROBE: begin
            if (cnt_q == '0) begin
              lat_en_q <= '0;
              if (THOLD > 0) begin
                state_q <= ST_HOLD;
                cnt_q   <= LD_HOLD;
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          ST_HOLD: begin
            if (cnt_q == '0) begin
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          default: begin
            state_q  <= ST_IDLE;
            lat_en_q <= '0;
          end
        endcase
      end
    end
  end

  assign lat_d    = lat_d_q;
  assign lat_en   = lat_en_q;
  assign addr_err = addr_err_q;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_latch_strobe_sequencer.sv
module tb_latch_strobe_sequencer;

  localparam int NI = 4;
  localparam int NR_A [NI] = '{16, 12, 16, 16};
  localparam int TS_A [NI] = '{1, 1, 2, 1};
  localparam int TP_A [NI] = '{2, 3, 1, 1};
  localparam int TH_A [NI] = '{1, 0, 2, 0};

  logic clk = 1'b0;
  logic rst;

  logic        req_valid_a [NI];
  logic [3:0]  req_addr_a  [NI];
  logic [7:0]  req_data_a  [NI];
  logic        ready_a     [NI];
  logic        busy_a      [NI];
  logic        err_a       [NI];
  logic [7:0]  lat_d_a     [NI];
  logic [15:0] lat_en_a    [NI];

  logic       f_push, f_pop, f_full, f_empty;
  logic [7:0] f_wdata, f_rdata;

  initial forever #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [NR_A[g]-1:0] en_w;
    latch_strobe_sequencer #(
      .DW(8), .NREG(NR_A[g]), .AW(4),
      .TSETUP(TS_A[g]), .TPULSE(TP_A[g]), .THOLD(TH_A[g])
    ) u_dut (
      .clk      (clk),
      .reset    (rst),
      .req_valid(req_valid_a[g]),
      .req_ready(ready_a[g]),
      .req_addr (req_addr_a[g]),
      .req_data (req_data_a[g]),
      .lat_d    (lat_d_a[g]),
      .lat_en   (en_w),
      .busy     (busy_a[g]),
      .addr_err (err_a[g])
    );
    assign lat_en_a[g] = 16'(en_w);
  end

  req_fifo2 #(.W(8)) u_fifo (
    .clk(clk), .reset(rst), .push_i(f_push), .pop_i(f_pop),
    .wdata_i(f_wdata), .rdata_o(f_rdata), .full_o(f_full), .empty_o(f_empty)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int stab_viol = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } sb_t;

  sb_t         exp_q   [NI][$];
  logic [15:0] prev_en [NI] = '{default: '0};
  logic [7:0]  prev_d  [NI] = '{default: '0};

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        if (req_valid_a[i] && ready_a[i]) exp_q[i].push_back('{addr: req_addr_a[i], data: req_data_a[i]});
      end
    end
  end

  task automatic sb_event(input int i, input bit is_err);
    sb_t e;
    logic [15:0] oh;
    check($sformatf("sb_pending_u%0d", i), exp_q[i].size() != 0, 1);
    if (exp_q[i].size() != 0) begin
      e = exp_q[i].pop_front();
      if (is_err) begin
        check($sformatf("sb_err_addr_u%0d", i), int'(e.addr) >= NR_A[i], 1);
      end else begin
        oh = (int'(e.addr) < NR_A[i]) ? (16'h1 << e.addr) : 16'h0;
        check($sformatf("sb_en_u%0d", i), lat_en_a[i], oh);
        check($sformatf("sb_data_u%0d", i), lat_d_a[i], e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        exp_q[i].delete();
      end else begin
        if ($countones(lat_en_a[i]) > 1) stab_viol++;
        if (prev_en[i] != 0 && lat_en_a[i] != 0 && lat_d_a[i] != prev_d[i]) stab_viol++;
        if (lat_en_a[i] != 0 && prev_en[i] == 0) sb_event(i, 1'b0);
        if (err_a[i]) sb_event(i, 1'b1);
      end
      prev_en[i] = lat_en_a[i];
      prev_d[i]  = lat_d_a[i];
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    int          inst;
    logic [3:0]  addr;
    logic [7:0]  data;
    logic [15:0] en;
    bit          err;
    int          ts;
    int          tp;
    int          th;
  } vec_t;

  vec_t vecs [11];

  // Called at a negedge; cycle 0 is the negedge after the accepting edge.
  task automatic run_vec(input vec_t v, input string tag);
    int k_d = -1, k_r = -1, pulse = 0, k_b = -1, n_err = 0, k_err = -1;
    logic [15:0] en_seen = '0;
    bit acc = 1'b0;
    int i = v.inst;
    req_valid_a[i] = 1'b1;
    req_addr_a[i]  = v.addr;
    req_data_a[i]  = v.data;
    for (int w = 0; w < 50; w++) begin
      acc = ready_a[i];
      @(posedge clk);
      if (acc) break;
      @(negedge clk);
    end
    @(negedge clk);
    req_valid_a[i] = 1'b0;
    check({tag, "_accepted"}, acc, 1);
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (k_d < 0 && lat_d_a[i] == v.data) k_d = k;
      if (lat_en_a[i] != 0) begin
        if (k_r < 0) begin
          k_r = k;
          en_seen = lat_en_a[i];
        end
        pulse++;
      end
      if (err_a[i]) begin
        n_err++;
        k_err = k;
      end
      if (k_b < 0 && !busy_a[i]) k_b = k;
    end
    check({tag, "_data_cycle"}, k_d, 1);
    check({tag, "_rise_cycle"}, k_r, v.err ? -1 : 1 + v.ts);
    check({tag, "_en_value"}, en_seen, v.en);
    check({tag, "_pulse_len"}, pulse, v.err ? 0 : v.tp);
    check({tag, "_busy_low"}, k_b, 1 + v.ts + v.tp + v.th);
    check({tag, "_err_count"}, n_err, v.err ? 1 : 0);
    check({tag, "_err_cycle"}, k_err, v.err ? 1 : -1);
  endtask

  // Three back-to-back requests into instance 0; returns observations.
  task automatic burst3(input logic [3:0] a0, input logic [7:0] d0, input int stop_k,
                        output bit rdy [7], output int rise_k [3], output logic [15:0] rise_v [3],
                        output int busy_low);
    int nr = 0;
    logic [15:0] pe = '0;
    busy_low = -1;
    for (int j = 0; j < 3; j++) begin
      rise_k[j] = -1;
      rise_v[j] = '0;
    end
    req_valid_a[0] = 1'b1;
    req_addr_a[0]  = a0;
    req_data_a[0]  = d0;
    for (int k = 0; k <= stop_k; k++) begin
      @(negedge clk);
      if (k < 7) rdy[k] = ready_a[0];
      if (k < 2) begin
        req_addr_a[0] = a0 + 4'(k + 1);
        req_data_a[0] = d0 + 8'(16 * (k + 1));
      end else begin
        req_valid_a[0] = 1'b0;
      end
      if (lat_en_a[0] != 0 && pe == 0 && nr < 3) begin
        rise_k[nr] = k;
        rise_v[nr] = lat_en_a[0];
        nr++;
      end
      pe = lat_en_a[0];
      if (busy_low < 0 && !busy_a[0]) busy_low = k;
    end
  endtask

  initial begin
    bit          rdy [7];
    int          rk [3];
    logic [15:0] rv [3];
    int          bl;
    bit          exp_rdy [7] = '{1, 1, 0, 0, 0, 1, 1};
    int          exp_rk [3]  = '{2, 6, 10};
    logic [15:0] exp_rv [3]  = '{16'h0001, 16'h0002, 16'h0004};
    int          en_hits;

    vecs[0]  = '{0, 4'd3,  8'hA5, 16'h0008, 1'b0, 1, 2, 1};
    vecs[1]  = '{0, 4'd15, 8'h5A, 16'h8000, 1'b0, 1, 2, 1};
    vecs[2]  = '{1, 4'd15, 8'h11, 16'h0000, 1'b1, 1, 3, 0};
    vecs[3]  = '{1, 4'd11, 8'h22, 16'h0800, 1'b0, 1, 3, 0};
    vecs[4]  = '{1, 4'd0,  8'h33, 16'h0001, 1'b0, 1, 3, 0};
    vecs[5]  = '{1, 4'd12, 8'h44, 16'h0000, 1'b1, 1, 3, 0};
    vecs[6]  = '{2, 4'd7,  8'hC3, 16'h0080, 1'b0, 2, 1, 2};
    vecs[7]  = '{2, 4'd12, 8'h3C, 16'h1000, 1'b0, 2, 1, 2};
    vecs[8]  = '{3, 4'd1,  8'h81, 16'h0002, 1'b0, 1, 1, 0};
    vecs[9]  = '{3, 4'd14, 8'h7E, 16'h4000, 1'b0, 1, 1, 0};
    vecs[10] = '{0, 4'd9,  8'h3C, 16'h0200, 1'b0, 1, 2, 1};

    rst = 1'b1;
    f_push = 1'b0; f_pop = 1'b0; f_wdata = '0;
    for (int i = 0; i < NI; i++) begin
      req_valid_a[i] = 1'b0;
      req_addr_a[i]  = '0;
      req_data_a[i]  = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_lat_en", lat_en_a[0], 0);
    check("rst_lat_d", lat_d_a[0], 0);
    check("rst_busy", busy_a[0], 0);
    check("rst_addr_err", err_a[0], 0);
    check("rst_ready_held", ready_a[0], 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", ready_a[0], 1);

    for (int v = 0; v < 10; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    // back-to-back burst: addr 0,1,2 on consecutive cycles
    check("b2b_ready_pre", ready_a[0], 1);
    burst3(4'd0, 8'h10, 14, rdy, rk, rv, bl);
    for (int k = 0; k < 7; k++) check($sformatf("b2b_ready_c%0d", k), rdy[k], exp_rdy[k]);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("b2b_rise_cycle%0d", j), rk[j], exp_rk[j]);
      check($sformatf("b2b_rise_en%0d", j), rv[j], exp_rv[j]);
    end
    check("b2b_busy_low", bl, 13);

    // reset while strobing
    burst3(4'd5, 8'h55, 2, rdy, rk, rv, bl);
    check("rst_mid_strobe_seen", rv[0], 16'h0020);
    #2 rst = 1'b1;
    #1;
    check("rst_async_en", lat_en_a[0], 0);
    check("rst_async_busy", busy_a[0], 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    en_hits = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (lat_en_a[0] != 0 || busy_a[0]) en_hits++;
    end
    check("rst_no_stale_strobe", en_hits, 0);
    run_vec(vecs[10], "post_rst");

    // FIFO push + pop while full
    check("fifo_empty_idle", f_empty, 1);
    f_push = 1'b1; f_wdata = 8'hA0;
    @(negedge clk);
    check("fifo_head_a0", f_rdata, 8'hA0);
    f_wdata = 8'hB1;
    @(negedge clk);
    check("fifo_full2", f_full, 1);
    f_wdata = 8'hC2; f_pop = 1'b1;
    @(negedge clk);
    f_push = 1'b0;
    check("fifo_full_after_pp", f_full, 1);
    check("fifo_head_b1", f_rdata, 8'hB1);
    @(negedge clk);
    check("fifo_one_left", f_full, 0);
    check("fifo_head_c2", f_rdata, 8'hC2);
    @(negedge clk);
    f_pop = 1'b0;
    check("fifo_drained", f_empty, 1);

    repeat (3) @(negedge clk);
    check("lat_d_stable_onehot", stab_viol, 0);
    for (int i = 0; i < NI; i++) check($sformatf("sb_drained_u%0d", i), exp_q[i].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
